// File: rtl/spongent_absorb.sv
// spongent_absorb
//   Iterative Spongent-88/176/88 permutation core for the absorb phase of the
//   Spongent hash. One round is evaluated per clock. A full permutation takes
//   ROUNDS cycles after the start edge.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   state_in   state to permute; sampled only on the start edge (IDLE & en)
//   en         level enable / start request
//   state_out  permuted state; valid while rdy=1, held otherwise
//   rdy        high when state_out holds a completed permutation
module spongent_absorb #(
   parameter int unsigned WIDTH     = 264,
   parameter int unsigned ROUNDS    = 135,
   parameter logic [7:0]  LFSR_INIT = 8'hD2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] state_in,
   input  logic             en,
   output logic [WIDTH-1:0] state_out,
   output logic             rdy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [7:0] CNT_LAST = 8'(ROUNDS - 1);

   logic [1:0]       r_fsm;
   logic [WIDTH-1:0] r_state;
   logic [WIDTH-1:0] r_out;
   logic [7:0]       r_lfsr;
   logic [7:0]       r_cnt;
   logic             r_rdy;

   logic [7:0]       w_lfsr_rev;
   logic [7:0]       w_lfsr_next;
   logic [WIDTH-1:0] w_rc;
   logic [WIDTH-1:0] w_sbox;
   logic [WIDTH-1:0] w_round;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hE;
         4'h1: y = 4'hD;
         4'h2: y = 4'hB;
         4'h3: y = 4'h0;
         4'h4: y = 4'h2;
         4'h5: y = 4'h1;
         4'h6: y = 4'h4;
         4'h7: y = 4'hF;
         4'h8: y = 4'h7;
         4'h9: y = 4'hA;
         4'hA: y = 4'h8;
         4'hB: y = 4'h5;
         4'hC: y = 4'h9;
         4'hD: y = 4'hC;
         4'hE: y = 4'h3;
         default: y = 4'h6;
      endcase
      return y;
   endfunction

   // x^8+x^4+x^3+x^2+1, shifting towards the MSB
   assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[3] ^ r_lfsr[2] ^ r_lfsr[1]};

   // Single-cycle round: round constant, S-box layer, pLayer
   always_comb begin
      w_lfsr_rev = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         w_lfsr_rev[7-i] = r_lfsr[i];
      end

      // lfsr goes into the low byte; its bit-reversal into the top byte
      w_rc = r_state ^ {w_lfsr_rev, {(WIDTH-16){1'b0}}, r_lfsr};

      w_sbox = '0;
      for (int unsigned k = 0; k < WIDTH/4; k++) begin
         w_sbox[9'(4*k) +: 4] = sbox(w_rc[9'(4*k) +: 4]);
      end

      // bit j -> (j*66) mod 263; the top bit is a fixed point
      w_round = '0;
      for (int unsigned j = 0; j < WIDTH-1; j++) begin
         w_round[9'((j * (WIDTH/4)) % (WIDTH-1))] = w_sbox[9'(j)];
      end
      w_round[WIDTH-1] = w_sbox[WIDTH-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fsm   <= S_IDLE;
         r_state <= '0;
         r_out   <= '0;
         r_lfsr  <= LFSR_INIT;
         r_cnt   <= '0;
         r_rdy   <= 1'b0;
      end else begin
         case (r_fsm)
            S_IDLE: begin
               if (en) begin
                  r_state <= state_in;
                  r_lfsr  <= LFSR_INIT;
                  r_cnt   <= '0;
                  r_fsm   <= S_RUN;
               end
            end
            S_RUN: begin
               r_state <= w_round;
               r_lfsr  <= w_lfsr_next;
               r_cnt   <= r_cnt + 8'd1;
               if (r_cnt == CNT_LAST) begin
                  r_out <= w_round;
                  r_rdy <= 1'b1;
                  r_fsm <= S_DONE;
               end
            end
            S_DONE: begin
               // en must drop before another start is accepted
               if (!en) begin
                  r_rdy <= 1'b0;
                  r_fsm <= S_IDLE;
               end
            end
            default: begin
               r_fsm <= S_IDLE;
            end
         endcase
      end
   end

   assign state_out = r_out;
   assign rdy       = r_rdy;

endmodule

// File: tb/tb_spongent_absorb.sv
// tb_spongent_absorb
//   Directed self-checking bench for spongent_absorb. Expected permutation
//   results come from a bit-level software model of Spongent-88/176/88.
module tb_spongent_absorb;

   logic         clk;
   logic         rst;
   logic [263:0] state_in;
   logic         en;
   logic [263:0] state_out;
   logic         rdy;

   int checks;
   int failures;

   spongent_absorb #(
      .WIDTH    (264),
      .ROUNDS   (135),
      .LFSR_INIT(8'hD2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .state_in (state_in),
      .en       (en),
      .state_out(state_out),
      .rdy      (rdy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- software model ----------------
   function automatic logic [3:0] m_sbox(input logic [3:0] x);
      logic [63:0] tab;
      tab = 64'h63C958A7F4120BDE;   // x=0 in the low nibble
      return tab[4*x +: 4];
   endfunction

   function automatic logic [263:0] model_perm(input logic [263:0] s_in);
      logic [263:0] s;
      logic [263:0] t;
      logic [7:0]   l;
      int unsigned  p;
      s = s_in;
      l = 8'hD2;
      for (int r = 0; r < 135; r++) begin
         for (int i = 0; i < 8; i++) begin
            s[i]       = s[i] ^ l[i];
            s[263 - i] = s[263 - i] ^ l[i];
         end
         for (int k = 0; k < 66; k++) begin
            s[4*k +: 4] = m_sbox(s[4*k +: 4]);
         end
         t = '0;
         p = 0;
         for (int j = 0; j < 263; j++) begin
            t[p] = s[j];
            p = p + 66;
            if (p >= 263) p = p - 263;
         end
         t[263] = s[263];
         s = t;
         l = {l[6:0], l[7] ^ l[3] ^ l[2] ^ l[1]};
      end
      return s;
   endfunction

   function automatic logic [263:0] rand_state();
      logic [287:0] v;
      for (int i = 0; i < 9; i++) v[32*i +: 32] = $urandom;
      return v[263:0];
   endfunction

   function automatic logic [263:0] hello_block();
      string        msg;
      logic [263:0] b;
      msg = "Hello World";
      b = '0;
      for (int i = 0; i < 11; i++) b[8*i +: 8] = msg[i];
      return b;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle();
      en = 1'b0;
      tick();
   endtask

   // Start edge, then count edges until rdy (bounded); -1 on timeout.
   task automatic start_run(input logic [263:0] s, output int lat);
      state_in = s;
      en       = 1'b1;
      tick();
      lat = -1;
      for (int n = 1; n <= 300; n++) begin
         tick();
         if (rdy === 1'b1) begin
            lat = n;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      en = 1'b1;
      state_in = '1;
      for (int c = 0; c < 10; c++) begin
         tick();
         checks++;
         if (rdy !== 1'b0) begin
            failures++;
            $display("FAIL reset_rdy cycle %0d: got %b expected 0", c, rdy);
         end
         checks++;
         if (state_out !== 264'd0) begin
            failures++;
            $display("FAIL reset_out cycle %0d: got %h expected 0", c, state_out);
         end
      end
      en = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      checks++;
      if (rdy !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_reset_rdy: got %b expected 0", rdy);
      end
   endtask

   task automatic test_latency_zero();
      int           lat;
      logic [263:0] exp;
      exp = model_perm('0);
      start_run('0, lat);
      checks++;
      if (lat !== 135) begin
         failures++;
         $display("FAIL latency_zero: got %0d edges expected 135", lat);
      end
      checks++;
      if (state_out !== exp) begin
         failures++;
         $display("FAIL perm_zero: got %h expected %h", state_out, exp);
      end
   endtask

   task automatic test_hello_absorb();
      int           lat;
      logic [263:0] blk;
      logic [263:0] exp1;
      logic [263:0] exp2;
      blk  = hello_block();
      exp1 = model_perm(blk);
      exp2 = model_perm(exp1 ^ blk);
      go_idle();
      start_run(blk, lat);
      checks++;
      if (lat !== 135 || state_out !== exp1) begin
         failures++;
         $display("FAIL hello_block1: got lat=%0d %h expected lat=135 %h", lat, state_out, exp1);
      end
      go_idle();
      checks++;
      if (rdy !== 1'b0) begin
         failures++;
         $display("FAIL hello_gap_rdy: got %b expected 0", rdy);
      end
      start_run(exp1 ^ blk, lat);
      checks++;
      if (lat !== 135 || state_out !== exp2) begin
         failures++;
         $display("FAIL hello_block2: got lat=%0d %h expected lat=135 %h", lat, state_out, exp2);
      end
   endtask

   task automatic test_hold_done();
      logic [263:0] exp;
      int           bad;
      exp = model_perm(model_perm(hello_block()) ^ hello_block());
      bad = 0;
      en  = 1'b1;
      for (int c = 0; c < 500; c++) begin
         state_in = rand_state();
         tick();
         if (rdy !== 1'b1 || state_out !== exp) bad++;
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL hold_done: got %0d bad cycles expected 0", bad);
      end
   endtask

   task automatic test_midrun_en_drop();
      logic [263:0] a;
      logic [263:0] exp;
      int           lat;
      a   = rand_state();
      exp = model_perm(a);
      go_idle();
      state_in = a;
      en = 1'b1;
      tick();
      lat = -1;
      for (int n = 1; n <= 300; n++) begin
         if (n == 51) begin
            state_in = rand_state();
            en = 1'b0;
         end
         tick();
         if (rdy === 1'b1) begin
            lat = n;
            break;
         end
      end
      checks++;
      if (lat !== 135) begin
         failures++;
         $display("FAIL midrun_en_latency: got %0d expected 135", lat);
      end
      checks++;
      if (state_out !== exp) begin
         failures++;
         $display("FAIL midrun_en_perm: got %h expected %h", state_out, exp);
      end
      tick();   // en=0 in DONE -> IDLE
   endtask

   task automatic test_midrun_reset();
      logic [263:0] c;
      logic [263:0] exp;
      int           lat;
      state_in = rand_state();
      en = 1'b1;
      tick();
      for (int n = 0; n < 70; n++) tick();
      rst = 1'b1;
      state_in = rand_state();
      tick();
      checks++;
      if (rdy !== 1'b0 || state_out !== 264'd0) begin
         failures++;
         $display("FAIL midrun_reset: got rdy=%b out=%h expected rdy=0 out=0", rdy, state_out);
      end
      rst = 1'b0;
      en = 1'b0;
      tick();
      c   = rand_state();
      exp = model_perm(c);
      start_run(c, lat);
      checks++;
      if (lat !== 135) begin
         failures++;
         $display("FAIL post_reset_latency: got %0d expected 135", lat);
      end
      checks++;
      if (state_out !== exp) begin
         failures++;
         $display("FAIL post_reset_perm: got %h expected %h", state_out, exp);
      end
   endtask

   task automatic test_back_to_back();
      logic [263:0] d;
      logic [263:0] exp;
      int           lat;
      d   = rand_state();
      exp = model_perm(d);
      go_idle();
      checks++;
      if (rdy !== 1'b0) begin
         failures++;
         $display("FAIL b2b_rdy_drop: got %b expected 0", rdy);
      end
      start_run(d, lat);
      checks++;
      if (lat !== 135) begin
         failures++;
         $display("FAIL b2b_latency: got %0d expected 135", lat);
      end
      checks++;
      if (state_out !== exp) begin
         failures++;
         $display("FAIL b2b_perm: got %h expected %h", state_out, exp);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      en       = 1'b0;
      state_in = '0;
      test_reset();
      test_latency_zero();
      test_hello_absorb();
      test_hold_done();
      test_midrun_en_drop();
      test_midrun_reset();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
